sockit_cdc_sink: RTL and testbench
==================================

// Module: sockit_cdc_sink
// PURPOSE
//  Receiver end of the req/grt stream protocol used on the sockit_cdc output port.
//  Drives a randomly throttled grant and accepts words. Checks each word against an
//  incrementing expected sequence. Reports transfer count, error count and the first mismatch.
//  Sits on the cdo side of sockit_cdc, in the cdo clock domain, for on-chip and bench self-test.
// PARAMETERS
//  DW    8             data width
//  CW    16            transfer counter width
//  EW    8             error counter width (saturating)
//  LEN   64            transfers per run, 1..2**CW-1
//  SEED  32'h00000001  LFSR reload value, nonzero
// PORTS
//  cdo_clk  in   1   clock
//  cdo_rst  in   1   reset, synchronous, active-high
//  cdo_clr  in   1   synchronous clear, same effect as reset
//  cdo_dat  in   DW  stream data, valid when cdo_req=1
//  cdo_req  in   1   stream request
//  cdo_grt  out  1   stream grant
//  cfg_str  in   1   start pulse
//  cfg_prb  in   32  grant probability threshold; all-ones forces grant
//  sts_run  out  1   run in progress
//  sts_end  out  1   run complete (LEN transfers)
//  sts_cnt  out  CW  transfers accepted this run
//  sts_err  out  EW  mismatches this run, saturates at all-ones
//  sts_exp  out  DW  expected value of first mismatch
//  sts_dat  out  DW  received value of first mismatch
// BEHAVIOUR
//  - One clock, cdo_clk. Reset is synchronous and active-high (cdo_rst). cdo_clr acts identically.
//    Both force: state IDLE; cdo_grt=0; all sts_*=0; expected=0; LFSR=SEED.
//  - Transfer: trn = cdo_req & cdo_grt, sampled at posedge cdo_clk. There is no combinational
//    path from cdo_req to cdo_grt.
//  - FSM IDLE -> RUN on cfg_str. RUN -> END on the trn that makes cnt == LEN.
//    END -> RUN on cfg_str. cfg_str is ignored while in RUN.
//  - Entering RUN clears cnt, err, expected, sts_exp and sts_dat. The LFSR is not reloaded.
//  - The LFSR is 32-bit Galois, polynomial 0x80200003. It steps every cycle in RUN and
//    holds in IDLE and END.
//  - Grant, registered, RUN only: if (~grt | trn) then grt <= (cfg_prb==all-ones) | (lfsr < cfg_prb).
//    Otherwise grt <= 1. Once asserted, grant holds until a transfer occurs.
//  - cdo_grt=0 in IDLE and END. Leaving RUN drops grant on the cycle after the last trn.
//  - Check on each trn: compare cdo_dat with expected[DW-1:0]. Expected increments mod 2**DW
//    regardless of the compare result. cnt increments.
//  - On mismatch: err += 1, saturating. If err was 0, latch sts_exp and sts_dat.
//  - sts_run=1 in RUN. sts_end=1 in END. All status outputs are registered; latency 1 cycle after trn.
//  - Simultaneous events: reset/clr beats cfg_str. A trn in the same cycle as clr is discarded.
//  - cdo_dat is ignored when no trn occurs; X on cdo_dat outside trn must not affect state.
// STRUCTURE
//  - Package sockit_cdc_pkg: state typedef (IDLE, RUN, END) and LFSR polynomial/width constants.
//  - One sub-module, sockit_lfsr: width, polynomial and seed parameters; ports clk, rst, clr, ena, out.
//  - Remaining logic lives in one file: FSM, grant register, counters, first-error capture.
// TESTING
//  1 Reset: hold cdo_rst 4 cycles with cdo_req=1.
//    -> cdo_grt=0, all sts_*=0, no trn counted.
//  2 Clean run: cfg_prb=all-ones, source sends 0,1,2.. with req held high, cfg_str pulse.
//    -> grt=1 from cycle 2, sts_end after 64 trn, sts_cnt=64, sts_err=0.
//  3 Corrupt word 5 as 8'h55, cfg_prb=32'h7fffffff.
//    -> sts_err=1, sts_exp=5, sts_dat=8'h55. Word 6 still accepted clean; final sts_err=1.
//  4 Grant hold: cfg_prb=0 once grt=1, cdo_req=0 for 10 cycles.
//    -> grt stays 1. First trn occurs when req rises, then grt drops.
//  5 Mid-run cdo_clr at cnt=20 with cfg_str in the same cycle.
//    -> next cycle IDLE, grt=0, sts_cnt=0. A later cfg_str restarts the run and checks from 0.
//  6 Saturation: EW=2, source sends constant 8'hff.
//    -> sts_err stops at 3; sts_exp=0, sts_dat=8'hff.

Source files
------------

// File: rtl/sockit_cdc_pkg.sv
// sockit_cdc_pkg: shared state encoding and LFSR constants for the cdc test sink
package sockit_cdc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, END} state_t;
  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h80200003;
endpackage

// File: rtl/sockit_lfsr.sv
// sockit_lfsr: right-shifting Galois LFSR with enable, reloaded with SEED on rst/clr
module sockit_lfsr
  import sockit_cdc_pkg::*;
#(
  parameter int           W    = LFSR_W,
  parameter logic [W-1:0] POLY = LFSR_POLY,
  parameter logic [W-1:0] SEED = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ena,
  output logic [W-1:0] out
);
  logic [W-1:0] out_q, out_d;
  always_comb out_d = ena ? ((out_q >> 1) ^ (out_q[0] ? POLY : '0)) : out_q;
  always_ff @(posedge clk) out_q <= (rst | clr) ? SEED : out_d;
  assign out = out_q;
endmodule

// File: rtl/sockit_cdc_sink.sv
// sockit_cdc_sink: throttled-grant stream receiver checking an incrementing word sequence
module sockit_cdc_sink
  import sockit_cdc_pkg::*;
#(
  parameter int          DW   = 8,
  parameter int          CW   = 16,
  parameter int          EW   = 8,
  parameter int          LEN  = 64,
  parameter logic [31:0] SEED = 32'h00000001
) (
  input  logic          cdo_clk,
  input  logic          cdo_rst,
  input  logic          cdo_clr,
  input  logic [DW-1:0] cdo_dat,
  input  logic          cdo_req,
  output logic          cdo_grt,
  input  logic          cfg_str,
  input  logic [31:0]   cfg_prb,
  output logic          sts_run,
  output logic          sts_end,
  output logic [CW-1:0] sts_cnt,
  output logic [EW-1:0] sts_err,
  output logic [DW-1:0] sts_exp,
  output logic [DW-1:0] sts_dat
);
  state_t        state_q, state_d;
  logic          grt_q, grt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] err_q, err_d;
  logic [DW-1:0] exp_q, exp_d, sexp_q, sexp_d, sdat_q, sdat_d;
  logic [31:0]   lfsr;
  logic          trn;
  sockit_lfsr #(.W(LFSR_W), .POLY(LFSR_POLY), .SEED(SEED)) u_lfsr (
    .clk(cdo_clk),
    .rst(cdo_rst),
    .clr(cdo_clr),
    .ena(state_q == RUN),
    .out(lfsr)
  );
  assign trn = cdo_req & grt_q;
  always_comb begin
    state_d = state_q;
    grt_d   = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    exp_d   = exp_q;
    sexp_d  = sexp_q;
    sdat_d  = sdat_q;
    if (state_q != RUN && cfg_str) begin
      state_d = RUN;
      cnt_d   = '0;
      err_d   = '0;
      exp_d   = '0;
      sexp_d  = '0;
      sdat_d  = '0;
    end
    if (state_q == RUN) begin
      // a raised grant is held until it is consumed, so the source never sees it retracted
      grt_d = (~grt_q | trn) ? (&cfg_prb | (lfsr < cfg_prb)) : 1'b1;
      if (trn) begin
        cnt_d = cnt_q + 1'b1;
        exp_d = exp_q + 1'b1;
        if (cdo_dat != exp_q) begin
          err_d = &err_q ? err_q : err_q + 1'b1;
          if (err_q == '0) begin
            sexp_d = exp_q;
            sdat_d = cdo_dat;
          end
        end
        if (cnt_d == CW'(LEN)) begin
          state_d = END;
          grt_d   = 1'b0;
        end
      end
    end
  end
  always_ff @(posedge cdo_clk) begin
    if (cdo_rst | cdo_clr) begin
      state_q <= IDLE;
      grt_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
      exp_q   <= '0;
      sexp_q  <= '0;
      sdat_q  <= '0;
    end else begin
      state_q <= state_d;
      grt_q   <= grt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      exp_q   <= exp_d;
      sexp_q  <= sexp_d;
      sdat_q  <= sdat_d;
    end
  end
  assign cdo_grt = grt_q;
  assign sts_run = state_q == RUN;
  assign sts_end = state_q == END;
  assign sts_cnt = cnt_q;
  assign sts_err = err_q;
  assign sts_exp = sexp_q;
  assign sts_dat = sdat_q;
endmodule

// File: tb/tb_sockit_cdc_sink.sv
// tb_sockit_cdc_sink: directed/randomized bench against a per-transfer scoreboard model
module tb_sockit_cdc_sink;
  logic        clk = 0, rst = 1, clr = 0, str = 0, req = 0;
  logic [7:0]  dat = 0;
  logic [31:0] prb = '1;
  logic        grt, run, en;
  logic [15:0] cnt;
  logic [7:0]  err, sexp, sdat;
  logic        str2 = 0, req2 = 0, grt2, run2, end2;
  logic [15:0] cnt2;
  logic [1:0]  err2;
  logic [7:0]  sexp2, sdat2;
  int n_vec = 0, n_err = 0;
  int m_mode = 0, m_cnt = 0, m_err = 0, m_nexp = 0, m_fe = 0, m_fd = 0;
  int src = 0, bad_idx = -1;
  bit rnd_req = 0;

  always #5 clk = ~clk;

  sockit_cdc_sink dut (
    .cdo_clk(clk), .cdo_rst(rst), .cdo_clr(clr), .cdo_dat(dat), .cdo_req(req),
    .cdo_grt(grt), .cfg_str(str), .cfg_prb(prb), .sts_run(run), .sts_end(en),
    .sts_cnt(cnt), .sts_err(err), .sts_exp(sexp), .sts_dat(sdat)
  );

  sockit_cdc_sink #(.EW(2), .LEN(16)) dut2 (
    .cdo_clk(clk), .cdo_rst(rst), .cdo_clr(1'b0), .cdo_dat(8'hff), .cdo_req(req2),
    .cdo_grt(grt2), .cfg_str(str2), .cfg_prb(32'hffffffff), .sts_run(run2), .sts_end(end2),
    .sts_cnt(cnt2), .sts_err(err2), .sts_exp(sexp2), .sts_dat(sdat2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic g, t;
    bit was_run;
    if (rnd_req) req = ($urandom % 4) != 0;
    dat = req ? ((src == bad_idx) ? 8'h55 : 8'(src)) : 8'($urandom);
    g = grt;
    t = req & g;
    was_run = (m_mode == 1);
    if (rst | clr) begin
      m_mode = 0; m_cnt = 0; m_err = 0; m_nexp = 0; m_fe = 0; m_fd = 0;
    end else if (m_mode != 1 && str) begin
      m_mode = 1; m_cnt = 0; m_err = 0; m_nexp = 0; m_fe = 0; m_fd = 0;
    end else if (m_mode == 1 && t) begin
      if (int'(dat) != m_nexp % 256) begin
        if (m_err == 0) begin m_fe = m_nexp % 256; m_fd = int'(dat); end
        if (m_err < 255) m_err++;
      end
      m_nexp++;
      m_cnt++;
      if (m_cnt == 64) m_mode = 2;
    end
    if (t) src++;
    @(posedge clk);
    @(negedge clk);
    chk("sts_cnt", 32'(cnt), 32'(m_cnt));
    chk("sts_err", 32'(err), 32'(m_err));
    chk("sts_exp", 32'(sexp), 32'(m_fe));
    chk("sts_dat", 32'(sdat), 32'(m_fd));
    chk("sts_run", 32'(run), 32'(m_mode == 1));
    chk("sts_end", 32'(en), 32'(m_mode == 2));
    if (!was_run || m_mode != 1) chk("grt_off", 32'(grt), 0);
    else if (g && !t) chk("grt_hold", 32'(grt), 1);
    else if (&prb) chk("grt_force", 32'(grt), 1);
    else if (prb == 0) chk("grt_zero", 32'(grt), 0);
  endtask

  task automatic run_to_end(input int bound);
    for (int i = 0; i < bound && m_mode == 1; i++) cyc();
    chk("end_reached", 32'(m_mode), 2);
  endtask

  initial begin
    @(negedge clk);
    // reset held with a requesting source
    rst = 1; req = 1;
    repeat (4) cyc();
    rst = 0; req = 0;
    cyc();
    // clean run, grant forced
    prb = '1; src = 0; str = 1; req = 1;
    cyc();
    str = 0;
    cyc();
    chk("grt_cycle2", 32'(grt), 1);
    run_to_end(200);
    chk("clean_cnt", 32'(cnt), 64);
    chk("clean_err", 32'(err), 0);
    // random throttle and random request, word 5 corrupted
    prb = 32'h7fffffff; src = 0; bad_idx = 5; rnd_req = 1; str = 1;
    cyc();
    str = 0;
    run_to_end(2000);
    rnd_req = 0; bad_idx = -1;
    chk("corrupt_err", 32'(err), 1);
    chk("corrupt_exp", 32'(sexp), 5);
    chk("corrupt_dat", 32'(sdat), 32'h55);
    // grant hold with an idle source
    prb = '1; src = 0; req = 0; str = 1;
    cyc();
    str = 0;
    for (int i = 0; i < 10 && !grt; i++) cyc();
    chk("hold_grt_up", 32'(grt), 1);
    prb = 0;
    repeat (10) cyc();
    chk("hold_grt_kept", 32'(grt), 1);
    req = 1;
    cyc();
    chk("hold_one_trn", 32'(cnt), 1);
    chk("hold_grt_drop", 32'(grt), 0);
    req = 0; clr = 1;
    cyc();
    clr = 0;
    // mid-run clear colliding with a start pulse
    prb = '1; src = 0; req = 1; str = 1;
    cyc();
    str = 0;
    for (int i = 0; i < 100 && cnt != 20; i++) cyc();
    chk("clr_at20", 32'(cnt), 20);
    clr = 1; str = 1;
    cyc();
    clr = 0; str = 0;
    chk("clr_idle", 32'(run), 0);
    chk("clr_cnt", 32'(cnt), 0);
    chk("clr_grt", 32'(grt), 0);
    repeat (2) cyc();
    src = 0; str = 1;
    cyc();
    str = 0;
    run_to_end(200);
    chk("restart_cnt", 32'(cnt), 64);
    chk("restart_err", 32'(err), 0);
    // saturation on the narrow-error instance with a constant 8'hff source
    req2 = 1; str2 = 1;
    @(posedge clk);
    @(negedge clk);
    str2 = 0;
    for (int i = 0; i < 60 && !end2; i++) @(negedge clk);
    chk("sat_end", 32'(end2), 1);
    chk("sat_cnt", 32'(cnt2), 16);
    chk("sat_err", 32'(err2), 3);
    chk("sat_exp", 32'(sexp2), 0);
    chk("sat_dat", 32'(sdat2), 32'hff);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
